pipe_stage_hs: RTL and testbench

Parametrised pipeline stage register with valid/ready handshake, synchronous flush and an optional two-entry skid buffer. It is the next-generation replacement for the fixed 32-bit, write-enable-driven stage registers between Fetch, Decode, Execute, Memory and Writeback. It carries LANES independent WIDTH-bit fields, such as instruction, operands and register values, as one packed bundle. Back-pressure propagates through valid/ready, not through a global write enable.

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/pipe_slot.sv | 43 ++++
 rtl/pipe_stage_hs.sv | 136 +++++++++++++
 tb/tb_pipe_stage_hs.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state type, default geometry and lane helper
// for the pipe_stage_hs valid/ready pipeline register.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

    localparam int unsigned PIPE_WIDTH = 32;
    localparam int unsigned PIPE_LANES = 4;

    function automatic int unsigned lane_lsb(
        input int unsigned k,
        input int unsigned w
    );
        return k * w;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one packed LANES*WIDTH register with load enable
// and synchronous clear of every lane to RST_VAL.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH   = PIPE_WIDTH,
    parameter int unsigned      LANES   = PIPE_LANES,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                   clk_i,
    input  logic                   clr_i,
    input  logic                   ld_i,
    input  logic [LANES*WIDTH-1:0] d_i,
    output logic [LANES*WIDTH-1:0] q_o
);

    logic [LANES*WIDTH-1:0] rst_vec;
    logic [LANES*WIDTH-1:0] data_q;
    logic [LANES*WIDTH-1:0] data_d;

    always_comb begin
        rst_vec = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            rst_vec[lane_lsb(k, WIDTH) +: WIDTH] = RST_VAL;
        end
    end

    always_comb begin
        data_d = data_q;
        if (clr_i) begin
            data_d = rst_vec;
        end else if (ld_i) begin
            data_d = d_i;
        end
    end

    always_ff @(posedge clk_i) begin
        data_q <= data_d;
    end

    assign q_o = data_q;

endmodule

// File: rtl/pipe_stage_hs.sv
// pipe_stage_hs: valid/ready pipeline stage with synchronous flush.
// Define PIPE_STAGE_SKID_EN for the skid entry and registered o_ready.
module pipe_stage_hs
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH   = PIPE_WIDTH,
    parameter int unsigned      LANES   = PIPE_LANES,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                   i_clk,
    input  logic                   i_s_rst_n,
    input  logic                   i_flush,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [LANES*WIDTH-1:0] i_data,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [LANES*WIDTH-1:0] o_data,
    output logic [1:0]             o_occ
);

    localparam int unsigned DW = LANES * WIDTH;

    pipe_state_t   state_q;
    pipe_state_t   state_d;
    logic          xfer_in;
    logic          xfer_out;
    logic          clr;
    logic          main_ld;
    logic [DW-1:0] main_d;

    assign clr      = ~i_s_rst_n | i_flush;
    assign o_valid  = (state_q != EMPTY);
    assign xfer_in  = i_valid & o_ready;
    assign xfer_out = o_valid & i_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic          skid_ld;
    logic          main_from_skid;
    logic          ready_q;
    logic [DW-1:0] skid_q;

    // Ready comes from a flop so i_ready never reaches o_ready.
    assign o_ready = ready_q;
    assign o_occ   = (state_q == FULL) ? 2'd2 : {1'b0, o_valid};
    assign main_d  = main_from_skid ? skid_q : i_data;

    always_ff @(posedge i_clk) begin
        if (!i_s_rst_n) begin
            ready_q <= 1'b1;
        end else begin
            ready_q <= (state_d != FULL);
        end
    end

    pipe_slot #(
        .WIDTH   (WIDTH),
        .LANES   (LANES),
        .RST_VAL (RST_VAL)
    ) u_skid (
        .clk_i (i_clk),
        .clr_i (clr),
        .ld_i  (skid_ld),
        .d_i   (i_data),
        .q_o   (skid_q)
    );
`else
    assign o_ready = ~o_valid | i_ready;
    assign o_occ   = {1'b0, o_valid};
    assign main_d  = i_data;
`endif

    always_comb begin
        state_d = state_q;
        main_ld = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
        skid_ld        = 1'b0;
        main_from_skid = 1'b0;
`endif
        if (i_flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (xfer_in) begin
                        state_d = BUSY;
                        main_ld = 1'b1;
                    end
                end
                BUSY: begin
                    if (xfer_in & xfer_out) begin
                        main_ld = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
                    end else if (xfer_in) begin
                        state_d = FULL;
                        skid_ld = 1'b1;
`endif
                    end else if (xfer_out) begin
                        state_d = EMPTY;
                    end
                end
`ifdef PIPE_STAGE_SKID_EN
                FULL: begin
                    if (xfer_out) begin
                        state_d        = BUSY;
                        main_ld        = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
`endif
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_s_rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    pipe_slot #(
        .WIDTH   (WIDTH),
        .LANES   (LANES),
        .RST_VAL (RST_VAL)
    ) u_main (
        .clk_i (i_clk),
        .clr_i (clr),
        .ld_i  (main_ld),
        .d_i   (main_d),
        .q_o   (o_data)
    );

endmodule

// File: tb/tb_pipe_stage_hs.sv
// tb_pipe_stage_hs: directed and random checks of pipe_stage_hs
// against a queue model of the stage contents.
module tb_pipe_stage_hs;

    localparam int DW = 128;
`ifdef PIPE_STAGE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    typedef logic [DW-1:0] bundle_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_flush;
    logic          i_valid;
    logic          i_ready;
    bundle_t       i_data;
    logic          o_ready;
    logic          o_valid;
    bundle_t       o_data;
    logic [1:0]    o_occ;

    logic [7:0]    d8;
    logic [7:0]    q8;
    logic          rdy8, vld8;
    logic [1:0]    occ8;
    logic [159:0]  d5;
    logic [159:0]  q5;
    logic          rdy5, vld5;
    logic [1:0]    occ5;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    bundle_t q[$];
    bundle_t src[$];
    bundle_t outlog[$];
    int      maxocc;

    always #5 clk = ~clk;

    pipe_stage_hs dut (
        .i_clk     (clk),
        .i_s_rst_n (rst_n),
        .i_flush   (i_flush),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_data    (i_data),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_data    (o_data),
        .o_occ     (o_occ)
    );

    pipe_stage_hs #(.WIDTH(8), .LANES(1)) dut8 (
        .i_clk     (clk),
        .i_s_rst_n (rst_n),
        .i_flush   (i_flush),
        .i_valid   (i_valid),
        .o_ready   (rdy8),
        .i_data    (d8),
        .o_valid   (vld8),
        .i_ready   (i_ready),
        .o_data    (q8),
        .o_occ     (occ8)
    );

    pipe_stage_hs #(.WIDTH(32), .LANES(5)) dut5 (
        .i_clk     (clk),
        .i_s_rst_n (rst_n),
        .i_flush   (i_flush),
        .i_valid   (i_valid),
        .o_ready   (rdy5),
        .i_data    (d5),
        .o_valid   (vld5),
        .i_ready   (i_ready),
        .o_data    (q5),
        .o_occ     (occ5)
    );

    task automatic chk(input string tag,
                       input logic [159:0] obs,
                       input logic [159:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check pre-edge outputs, advance model.
    task automatic cycle(input logic v, input logic r, input logic fl,
                         input bundle_t d, output bit acc);
        bit rdy;
        @(negedge clk);
        i_valid = v;
        i_ready = r;
        i_flush = fl;
        i_data  = d;
        #1;
        if (CAP == 2) rdy = (q.size() < 2);
        else          rdy = (q.size() == 0) || r;
        chk("ready", o_ready, rdy);
        chk("valid", o_valid, q.size() != 0);
        chk("occ",   o_occ,   q.size());
        if (q.size() != 0) chk("data", o_data, q[0]);
        if (o_valid && r) outlog.push_back(o_data);
        if (o_occ > maxocc) maxocc = o_occ;
        acc = v && rdy && !fl;
        if (fl) begin
            q.delete();
        end else begin
            if (q.size() != 0 && r) void'(q.pop_front());
            if (acc) q.push_back(d);
        end
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        rst_n   = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_flush = 1'b0;
        #1;
        chk({tag, "_valid"}, o_valid, 0);
        chk({tag, "_data"},  o_data,  0);
        chk({tag, "_occ"},   o_occ,   0);
        chk({tag, "_ready"}, o_ready, 1);
    endtask

    function automatic bundle_t rnd();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        bit acc;
        bit rp[8];
        logic [159:0] exp5;

        rst_n   = 1'b0;
        i_flush = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_data  = '0;
        d8      = 8'hF0;
        for (int k = 0; k < 5; k++) d5[k*32 +: 32] = 32'hF0 + k;
        exp5 = d5;
        maxocc = 0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_valid", o_valid, 0);
        chk("rst_data",  o_data,  0);
        chk("rst_occ",   o_occ,   0);
        chk("rst_ready", o_ready, 1);
        rst_n = 1'b1;

        // Streaming 1..8 in lane 0, full throughput
        outlog.delete();
        for (int k = 1; k <= 8; k++) begin
            cycle(1, 1, 0, {32'(k + 3), 32'(k + 2), 32'(k + 1), 32'(k)}, acc);
            chk("stream_acc", acc, 1);
        end
        cycle(0, 1, 0, '0, acc);
        chk("stream_cnt", outlog.size(), 8);
        for (int k = 0; k < 8 && k < outlog.size(); k++)
            chk("stream_lane0", outlog[k][31:0], k + 1);

        // Back-pressure with A,B,C
        src = '{bundle_t'(128'hA), bundle_t'(128'hB), bundle_t'(128'hC)};
        rp  = '{1, 0, 0, 0, 1, 1, 1, 1};
        outlog.delete();
        maxocc = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(src.size() != 0, rp[i], 0,
                  (src.size() != 0) ? src[0] : '0, acc);
            if (acc) void'(src.pop_front());
        end
        chk("bp_maxocc", maxocc, CAP);
        chk("bp_cnt", outlog.size(), 3);
        if (outlog.size() == 3) begin
            chk("bp_out0", outlog[0], 128'hA);
            chk("bp_out1", outlog[1], 128'hB);
            chk("bp_out2", outlog[2], 128'hC);
        end

        // Flush with 0x11/0x22 held, 0x33 offered in the flush cycle
        cycle(1, 0, 0, 128'h11, acc);
        cycle(1, 0, 0, 128'h22, acc);
        cycle(1, 0, 1, 128'h33, acc);
        check_idle("flush");
        cycle(0, 1, 0, '0, acc);

        // Reset while holding 0x55, 0x66 offered during reset
        cycle(1, 1, 0, 128'h55, acc);
        @(negedge clk);
        rst_n   = 1'b0;
        i_valid = 1'b1;
        i_ready = 1'b0;
        i_data  = 128'h66;
        q.delete();
        check_idle("rst_mid");
        cycle(0, 1, 0, '0, acc);
        cycle(0, 1, 0, '0, acc);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 15) == 0, rnd(), acc);
        end

        // Lane geometry sweep
        repeat (3) cycle(0, 1, 0, '0, acc);
        cycle(1, 1, 0, rnd(), acc);
        cycle(0, 0, 0, '0, acc);
        chk("w8_valid", vld8, 1);
        chk("w8_data",  q8,   8'hF0);
        chk("w8_occ",   occ8, 1);
        chk("l5_valid", vld5, 1);
        chk("l5_data",  q5,   exp5);
        chk("l5_occ",   occ5, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
